evm_ballot_unit: RTL and testbench
==================================

Name: evm_ballot_unit

Overview:
- Voter-side ballot unit of the voting machine: arms on an enable pulse from the control unit and accepts exactly one candidate button press per arming.
- Debounces the press and transmits the candidate code to the control unit over a one-wire serial frame, then waits for an acknowledge.
- On acknowledge, drives the vote-cast beep. The control unit's vote counters receive these frames.

Parameters:
- NUM_CAND, 4, number of candidate buttons (2..16); candidate code width CODE_W = clog2(NUM_CAND), localparam.
- DEBOUNCE_CYCLES, 16, clock cycles a single button must be stable before it is accepted.
- BIT_CYCLES, 4, clock cycles per serial bit on tx_line.
- ACK_TIMEOUT, 64, cycles to wait for cu_ack after the frame ends.
- MAX_RETRY, 2, retransmissions after the first attempt before error.
- BEEP_CYCLES, 32, duration of the beep pulse.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset; asynchronous, active-high.
- ballot_en, input, 1, arm request from control unit; synchronous, rising edge is significant.
- btn, input, NUM_CAND, raw candidate buttons, asynchronous, active-high.
- cu_ack, input, 1, single-cycle acknowledge from control unit, synchronous.
- tx_line, output, 1, serial frame to control unit, idle 0.
- led_ready, output, 1, ballot armed, voter may press.
- busy, output, 1, high in every state except IDLE and ERROR.
- beep, output, 1, vote-cast indication.
- err, output, 1, sticky link-failure flag.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, all counters 0, retry count 0.
- btn passes through a 2-flop synchronizer; all decisions use the synchronized value.
- ballot_en rising edge is detected with one register; a level held high arms only once.

FSM states:
- IDLE: buttons ignored. ballot_en rising edge -> ARMED. led_ready=1 from the next cycle.
- ARMED: waits for the synchronized btn to be exactly one-hot. Then latches index as code and -> DEBOUNCE with counter=0.
  - Zero buttons, or two or more buttons, do nothing.
- DEBOUNCE: counter increments each cycle btn equals the latched one-hot value.
  - Any change (release, or another button added) -> ARMED; the press is rejected.
  - counter reaches DEBOUNCE_CYCLES-1 -> SEND; led_ready=0 on the same transition.
- SEND: frame is start bit 1, CODE_W data bits MSB first, then even-parity bit (XOR of data bits). Each bit is held BIT_CYCLES cycles.
  - Total frame length is (CODE_W+2)*BIT_CYCLES cycles.
  - tx_line returns to 0 after the parity bit -> WAIT_ACK.
- WAIT_ACK: cu_ack=1 -> BEEP.
  - Timeout counter reaching ACK_TIMEOUT with retry<MAX_RETRY: retry+1 -> SEND, same code.
  - Timeout with retry=MAX_RETRY -> ERROR.
  - cu_ack in any other state is ignored.
- BEEP: beep=1 for exactly BEEP_CYCLES cycles, then -> IDLE with retry cleared. Buttons ignored.
- ERROR: err=1, busy=0, tx_line=0, led_ready=0. Leaves only via rst.

Simultaneous events and boundaries:
- ballot_en edges outside IDLE are ignored (no re-arm, no queueing).
- Button held through BEEP into the next arming: it is accepted only if still uniquely held after arming; no edge is required.
- rst mid-frame forces tx_line=0 asynchronously; the partial frame is abandoned.
- NUM_CAND=2 gives CODE_W=1.
- All counters are sized to their parameter; no wrap-around occurs inside any state.

Optional Feature:
- Macro VVPAT_EN: when defined, adds output vvpat_valid (1) and vvpat_code (CODE_W).
  - On entry to BEEP, vvpat_code=code and vvpat_valid=1 for the whole BEEP state, then both return to 0.
  - Both reset to 0.
- Without the macro these ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then ballot_en pulse, btn=4'b0100 held 20 cycles -> led_ready rises, then frame 1,1,0,1 (code 2, parity 1) at 4 cycles/bit; cu_ack after frame -> beep high 32 cycles, then IDLE.
- Armed, btn=4'b0011 held 50 cycles -> no frame, led_ready stays 1; then release to 4'b0001 -> frame 1,0,0,0.
- Armed, btn=4'b1000 held 8 cycles then released -> no frame, ARMED; re-press 20 cycles -> frame 1,1,1,0.
- Never assert cu_ack -> frame sent 3 times, each followed by 64-cycle wait, then err=1, busy=0; ballot_en ignored until rst.
- Press accepted, second ballot_en pulse during SEND and btn presses during BEEP -> single frame, single beep, returns to IDLE unarmed.
- rst asserted mid-frame -> tx_line=0 immediately, all outputs 0; with VVPAT_EN, vvpat_valid=1 and vvpat_code=2 exactly during beep of scenario 1.

Source files
------------

// File: rtl/evm_ballot_unit.sv
// Voter-side ballot unit: arms on ballot_en, debounces one candidate button, sends the code
// over a one-wire serial frame, retries on ack timeout, then beeps. Optional VVPAT_EN adds vvpat_valid/vvpat_code.
module evm_ballot_unit #(
    parameter int NUM_CAND        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BIT_CYCLES      = 4,
    parameter int ACK_TIMEOUT     = 64,
    parameter int MAX_RETRY       = 2,
    parameter int BEEP_CYCLES     = 32,
    localparam int CODE_W         = $clog2(NUM_CAND)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ballot_en,
    input  logic [NUM_CAND-1:0] btn,
    input  logic                cu_ack,
    output logic                tx_line,
    output logic                led_ready,
    output logic                busy,
    output logic                beep,
    output logic                err
`ifdef VVPAT_EN
    ,
    output logic                vvpat_valid,
    output logic [CODE_W-1:0]   vvpat_code
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARMED    = 3'd1;
    localparam logic [2:0] S_DEBOUNCE = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_WAIT_ACK = 3'd4;
    localparam logic [2:0] S_BEEP     = 3'd5;
    localparam logic [2:0] S_ERROR    = 3'd6;

    localparam int FRAME_LEN   = CODE_W + 2;
    localparam int IDX_W       = $clog2(FRAME_LEN);
    localparam int FRAME_SLOTS = 1 << IDX_W;
    localparam int DEB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BIT_W       = $clog2(BIT_CYCLES + 1);
    localparam int TOUT_W      = $clog2(ACK_TIMEOUT + 1);
    localparam int RTY_W       = $clog2(MAX_RETRY + 2);
    localparam int BEEP_W      = $clog2(BEEP_CYCLES + 1);

    logic [NUM_CAND-1:0] btn_meta_reg, btn_sync_reg;
    logic                en_prev_reg;
    logic [2:0]          state_reg, state_next;
    logic [CODE_W-1:0]   code_reg, code_next;
    logic                led_ready_reg, led_ready_next;
    logic [DEB_W-1:0]    deb_cnt_reg, deb_cnt_next;
    logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [IDX_W-1:0]    bit_idx_reg, bit_idx_next;
    logic [TOUT_W-1:0]   tout_cnt_reg, tout_cnt_next;
    logic [RTY_W-1:0]    retry_reg, retry_next;
    logic [BEEP_W-1:0]   beep_cnt_reg, beep_cnt_next;

    logic                en_rise;
    logic                btn_onehot;
    logic [CODE_W-1:0]   btn_idx;
    logic [NUM_CAND-1:0] code_mask;
    logic [FRAME_SLOTS-1:0] frame_bits;

    assign en_rise    = ballot_en & ~en_prev_reg;
    assign btn_onehot = (btn_sync_reg != '0) && ((btn_sync_reg & (btn_sync_reg - 1'b1)) == '0);

    always_comb begin
        btn_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (btn_sync_reg[i]) btn_idx = CODE_W'(i);
        end
    end

    // Frame slot 0 is the start bit, data MSB first, then even parity; unused slots read 0.
    generate
        for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_mask
            assign code_mask[gi] = (code_reg == CODE_W'(gi));
        end
        for (genvar gi = 0; gi < FRAME_SLOTS; gi++) begin : g_frame
            if (gi == 0) begin : g_start
                assign frame_bits[gi] = 1'b1;
            end else if (gi <= CODE_W) begin : g_data
                assign frame_bits[gi] = code_reg[CODE_W-gi];
            end else if (gi == CODE_W + 1) begin : g_par
                assign frame_bits[gi] = ^code_reg;
            end else begin : g_pad
                assign frame_bits[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        code_next      = code_reg;
        led_ready_next = led_ready_reg;
        deb_cnt_next   = deb_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        bit_idx_next   = bit_idx_reg;
        tout_cnt_next  = tout_cnt_reg;
        retry_next     = retry_reg;
        beep_cnt_next  = beep_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (en_rise) begin
                    state_next     = S_ARMED;
                    led_ready_next = 1'b1;
                end
            end
            S_ARMED: begin
                if (btn_onehot) begin
                    code_next    = btn_idx;
                    deb_cnt_next = '0;
                    state_next   = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (btn_sync_reg != code_mask) begin
                    state_next = S_ARMED;
                end else if (deb_cnt_reg == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_next     = S_SEND;
                    led_ready_next = 1'b0;
                    bit_cnt_next   = '0;
                    bit_idx_next   = '0;
                end else begin
                    deb_cnt_next = deb_cnt_reg + 1'b1;
                end
            end
            S_SEND: begin
                if (bit_cnt_reg == BIT_W'(BIT_CYCLES - 1)) begin
                    bit_cnt_next = '0;
                    if (bit_idx_reg == IDX_W'(FRAME_LEN - 1)) begin
                        state_next    = S_WAIT_ACK;
                        tout_cnt_next = '0;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (cu_ack) begin
                    state_next    = S_BEEP;
                    beep_cnt_next = '0;
                end else if (tout_cnt_reg == TOUT_W'(ACK_TIMEOUT - 1)) begin
                    if (retry_reg < RTY_W'(MAX_RETRY)) begin
                        retry_next   = retry_reg + 1'b1;
                        state_next   = S_SEND;
                        bit_cnt_next = '0;
                        bit_idx_next = '0;
                    end else begin
                        state_next = S_ERROR;
                    end
                end else begin
                    tout_cnt_next = tout_cnt_reg + 1'b1;
                end
            end
            S_BEEP: begin
                if (beep_cnt_reg == BEEP_W'(BEEP_CYCLES - 1)) begin
                    state_next = S_IDLE;
                    retry_next = '0;
                end else begin
                    beep_cnt_next = beep_cnt_reg + 1'b1;
                end
            end
            S_ERROR: ;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_reg  <= '0;
            btn_sync_reg  <= '0;
            en_prev_reg   <= 1'b0;
            state_reg     <= S_IDLE;
            code_reg      <= '0;
            led_ready_reg <= 1'b0;
            deb_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            bit_idx_reg   <= '0;
            tout_cnt_reg  <= '0;
            retry_reg     <= '0;
            beep_cnt_reg  <= '0;
        end else begin
            btn_meta_reg  <= btn;
            btn_sync_reg  <= btn_meta_reg;
            en_prev_reg   <= ballot_en;
            state_reg     <= state_next;
            code_reg      <= code_next;
            led_ready_reg <= led_ready_next;
            deb_cnt_reg   <= deb_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            tout_cnt_reg  <= tout_cnt_next;
            retry_reg     <= retry_next;
            beep_cnt_reg  <= beep_cnt_next;
        end
    end

    // Outputs decode from registered state, so an async reset clears them immediately.
    assign tx_line   = (state_reg == S_SEND) & frame_bits[bit_idx_reg];
    assign led_ready = led_ready_reg;
    assign busy      = (state_reg != S_IDLE) && (state_reg != S_ERROR);
    assign beep      = (state_reg == S_BEEP);
    assign err       = (state_reg == S_ERROR);

`ifdef VVPAT_EN
    assign vvpat_valid = (state_reg == S_BEEP);
    assign vvpat_code  = (state_reg == S_BEEP) ? code_reg : '0;
`endif

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Scoreboard bench for evm_ballot_unit: stimulus pushes expected frames/beeps,
// independent monitors capture tx_line waveforms and beep pulses and compare.
module tb_evm_ballot_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ballot_en = 1'b0;
    logic       cu_ack = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic       tx_line, led_ready, busy, beep, err;
`ifdef VVPAT_EN
    logic       vvpat_valid;
    logic [1:0] vvpat_code;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] frame_q[$];
    int         beep_q[$];

    evm_ballot_unit dut (
        .clk       (clk),
        .rst       (rst),
        .ballot_en (ballot_en),
        .btn       (btn),
        .cu_ack    (cu_ack),
        .tx_line   (tx_line),
        .led_ready (led_ready),
        .busy      (busy),
        .beep      (beep),
        .err       (err)
`ifdef VVPAT_EN
        ,
        .vvpat_valid (vvpat_valid),
        .vvpat_code  (vvpat_code)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm();
        ballot_en = 1'b1;
        cyc(1);
        ballot_en = 1'b0;
        check("led_ready_armed", led_ready, 1);
    endtask

    task automatic give_ack();
        cu_ack = 1'b1;
        cyc(1);
        cu_ack = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy !== 1'b0 && k < 300) begin
            cyc(1);
            k++;
        end
        check(name, busy, 0);
    endtask

    // Frame monitor: captures 16 frame cycles plus the first idle cycle after it.
    initial begin : frame_mon
        logic [16:0] got, expw;
        logic [3:0]  e;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (!rst && tx_line === 1'b1) begin
                got = '0;
                got[0] = 1'b1;
                aborted = 1'b0;
                for (int i = 1; i < 17; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    got[i] = tx_line;
                end
                if (frame_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got waveform %b, required no frame", got);
                end else begin
                    e = frame_q.pop_front();
                    if (aborted) begin
                        $display("frame aborted by reset, expected tag %b", e);
                        check("frame_abort", {28'b0, e}, 0);
                    end else begin
                        for (int i = 0; i < 16; i++) expw[i] = e[3 - i / 4];
                        expw[16] = 1'b0;
                        $display("frame: expected bits %b, waveform %b", e, got);
                        check("frame_wave", {15'b0, got}, {15'b0, expw});
                    end
                end
                if (aborted) wait (!rst);
            end
        end
    end

    // Beep monitor: measures pulse length and VVPAT fields during the pulse.
    initial begin : beep_mon
        int len;
        int exp_code;
        bit vv_bad;
        forever begin
            @(negedge clk);
            if (!rst && beep === 1'b1) begin
                len = 0;
                vv_bad = 1'b0;
                exp_code = (beep_q.size() != 0) ? beep_q.pop_front() : -1;
                while (beep === 1'b1 && len < 200) begin
`ifdef VVPAT_EN
                    if (vvpat_valid !== 1'b1 || int'(vvpat_code) != exp_code) vv_bad = 1'b1;
`endif
                    len++;
                    @(negedge clk);
                end
                $display("beep: code %0d, length %0d", exp_code, len);
                check("beep_expected", (exp_code >= 0) ? 1 : 0, 1);
                check("beep_len", len, 32);
                check("vvpat_during_beep", {31'b0, vv_bad}, 0);
`ifdef VVPAT_EN
                check("vvpat_valid_after", vvpat_valid, 0);
                check("vvpat_code_after", vvpat_code, 0);
`endif
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k;
        // Reset state
        cyc(3);
        check("rst_tx", tx_line, 0);
        check("rst_led", led_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_beep", beep, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        cyc(2);
        $display("txn: reset released");

        // Scenario 1: code 2 -> frame 1,1,0,1
        arm();
        check("busy_armed", busy, 1);
        frame_q.push_back(4'b1101);
        btn = 4'b0100;
        cyc(20);
        btn = 4'b0000;
        check("led_ready_low_in_send", led_ready, 0);
        cyc(16);
        beep_q.push_back(2);
        give_ack();
        wait_idle("idle_after_s1");
        check("led_idle_s1", led_ready, 0);
        $display("txn: scenario 1 done");

        // Scenario 2: two buttons ignored, then single button 0
        arm();
        btn = 4'b0011;
        cyc(50);
        check("led_two_buttons", led_ready, 1);
        check("tx_two_buttons", tx_line, 0);
        frame_q.push_back(4'b1000);
        btn = 4'b0001;
        cyc(20);
        btn = 4'b0000;
        cyc(16);
        beep_q.push_back(0);
        give_ack();
        wait_idle("idle_after_s2");
        $display("txn: scenario 2 done");

        // Scenario 3: short press rejected, re-press accepted (code 3)
        arm();
        btn = 4'b1000;
        cyc(8);
        btn = 4'b0000;
        cyc(10);
        check("led_after_short", led_ready, 1);
        check("busy_after_short", busy, 1);
        frame_q.push_back(4'b1110);
        btn = 4'b1000;
        cyc(20);
        btn = 4'b0000;
        cyc(16);
        beep_q.push_back(3);
        give_ack();
        wait_idle("idle_after_s3");
        $display("txn: scenario 3 done");

        // Scenario 5: ballot_en during SEND ignored, presses during BEEP ignored,
        // button held into next arming is accepted without a new edge
        arm();
        frame_q.push_back(4'b1011);
        btn = 4'b0010;
        cyc(20);
        btn = 4'b0000;
        ballot_en = 1'b1;
        cyc(1);
        ballot_en = 1'b0;
        cyc(15);
        beep_q.push_back(1);
        give_ack();
        btn = 4'b0001;
        wait_idle("idle_after_s5");
        check("led_unarmed_s5", led_ready, 0);
        cyc(20);
        check("busy_unarmed_s5", busy, 0);
        check("tx_unarmed_s5", tx_line, 0);
        frame_q.push_back(4'b1000);
        arm();
        cyc(20);
        btn = 4'b0000;
        cyc(16);
        beep_q.push_back(0);
        give_ack();
        wait_idle("idle_after_s5b");
        $display("txn: scenario 5 done");

        // Scenario 4: no ack -> three frames then ERROR
        arm();
        frame_q.push_back(4'b1101);
        frame_q.push_back(4'b1101);
        frame_q.push_back(4'b1101);
        btn = 4'b0100;
        k = 0;
        while (err !== 1'b1 && k < 400) begin
            cyc(1);
            k++;
            if (k == 20) btn = 4'b0000;
        end
        check("err_latency", k, 259);
        check("err_set", err, 1);
        check("err_busy", busy, 0);
        check("err_led", led_ready, 0);
        check("err_tx", tx_line, 0);
        ballot_en = 1'b1;
        cyc(1);
        ballot_en = 1'b0;
        cyc(5);
        check("err_no_rearm_led", led_ready, 0);
        check("err_sticky", err, 1);
        rst = 1'b1;
        #1;
        check("err_cleared_by_rst", err, 0);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        $display("txn: scenario 4 done");

        // Scenario 6: reset in the middle of a frame
        arm();
        frame_q.push_back(4'b0000);
        btn = 4'b0100;
        cyc(25);
        check("tx_mid_frame", tx_line, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", tx_line, 0);
        check("rst_mid_led", led_ready, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_beep", beep, 0);
        check("rst_mid_err", err, 0);
        cyc(2);
        btn = 4'b0000;
        rst = 1'b0;
        cyc(20);
        $display("txn: scenario 6 done");

        check("frame_q_empty", frame_q.size(), 0);
        check("beep_q_empty", beep_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
